// File: rtl/shift_cmd_sequencer_pkg.sv
// Op/MODE codes shared with the universal shift register,
// plus the command sequencer state encoding.
package shift_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_ROR  = 2'b01;
  localparam logic [1:0] OP_ROL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/shift_cmd_sequencer.sv
// Command front-end for the universal shift register:
// load / rotate N / hold N, one command in flight.
module shift_cmd_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_din,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state;
  state_t           state_nx;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] data_r;
  logic             accept;
  logic             is_load;
  logic             is_rot;
  logic             last;

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  assign is_load = (op_r == OP_LOAD);
  assign is_rot  = (op_r == OP_ROR) || (op_r == OP_ROL);
  assign last    = is_load || (rem == CNT_W'(1));

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_LOAD || cmd_count != '0)
            state_nx = ST_EXEC;
          else
            state_nx = ST_WAIT;
        end
      end
      ST_EXEC: if (last) state_nx = ST_WAIT;
      ST_WAIT: state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Rotates feed the register's own output back in,
  // so every EXEC cycle is exactly one rotation step.
  always_comb begin
    sr_mode = OP_HOLD;
    sr_din  = '0;
    if (state == ST_EXEC) begin
      sr_mode = op_r;
      unique case (1'b1)
        is_load: sr_din = data_r;
        is_rot:  sr_din = sr_q;
        default: sr_din = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_r   <= OP_HOLD;
      rem    <= '0;
      data_r <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_r   <= cmd_op;
        rem    <= cmd_count;
        data_r <= cmd_data;
      end else if (state == ST_EXEC && rem != '0) begin
        rem <= rem - CNT_W'(1);
      end
      if (state == ST_WAIT)
        result <= sr_q;
    end
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Self-checking bench for shift_cmd_sequencer with a
// behavioural shift register and a rotate-arithmetic model.
module tb_shift_cmd_sequencer;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [CW-1:0] cmd_count = '0;
  logic [W-1:0]  cmd_data = '0;
  logic [1:0]    sr_mode;
  logic [W-1:0]  sr_din;
  logic [W-1:0]  sr_q;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  int n_tests = 0;
  int n_fail  = 0;

  shift_cmd_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count),
    .cmd_data(cmd_data),
    .sr_mode(sr_mode), .sr_din(sr_din), .sr_q(sr_q),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Universal shift register the sequencer drives
  always @(posedge clk) begin
    if (rst) sr_q <= '0;
    else begin
      case (sr_mode)
        2'b01: sr_q <= {sr_din[0], sr_q[W-1:1]};
        2'b10: sr_q <= {sr_q[W-2:0], sr_din[W-1]};
        2'b11: sr_q <= sr_din;
        default: sr_q <= sr_q;
      endcase
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic int model_res(int q, int op, int cnt,
                                   int d);
    int n;
    n = cnt % W;
    if (op == 3) return d;
    if (op == 1) return ((q >> n) | (q << (W - n))) & 15;
    if (op == 2) return ((q << n) | (q >> (W - n))) & 15;
    return q;
  endfunction

  function automatic int model_lat(int op, int cnt);
    if (op == 3) return 3;
    if (cnt == 0) return 2;
    return cnt + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!cmd_ready && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic wait_done(output int lat,
                           output logic [W-1:0] res);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    res = result;
  endtask

  task automatic send(input logic [1:0] op,
                      input logic [CW-1:0] cnt,
                      input logic [W-1:0] d,
                      output int lat,
                      output logic [W-1:0] res);
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = d;
    cmd_valid = 1'b1;
    wait_ready();
    tick();
    cmd_valid = 1'b0;
    wait_done(lat, res);
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [CW-1:0] cnt;
    logic [W-1:0]  data;
    logic [W-1:0]  res;
    int            lat;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int lat, dc, c, nd;
    logic [W-1:0] res, res1;
    logic [W-1:0] rol_seq[3];
    int q_ref, op, cnt, d;

    tbl[0]  = '{2'b11, 4'd0,  4'b1011, 4'b1011, 3};
    tbl[1]  = '{2'b01, 4'd1,  4'hf,    4'b1101, 3};
    tbl[2]  = '{2'b11, 4'd7,  4'b1011, 4'b1011, 3};
    tbl[3]  = '{2'b10, 4'd3,  4'h0,    4'b1101, 5};
    tbl[4]  = '{2'b11, 4'd0,  4'b1011, 4'b1011, 3};
    tbl[5]  = '{2'b01, 4'd4,  4'h5,    4'b1011, 6};
    tbl[6]  = '{2'b01, 4'd0,  4'h0,    4'b1011, 2};
    tbl[7]  = '{2'b00, 4'd5,  4'ha,    4'b1011, 7};
    tbl[8]  = '{2'b10, 4'd15, 4'h0,    4'b1101, 17};
    tbl[9]  = '{2'b11, 4'd3,  4'b0000, 4'b0000, 3};
    tbl[10] = '{2'b01, 4'd9,  4'hf,    4'b0000, 11};
    tbl[11] = '{2'b11, 4'd0,  4'b1000, 4'b1000, 3};
    tbl[12] = '{2'b01, 4'd2,  4'h0,    4'b0010, 4};
    tbl[13] = '{2'b10, 4'd0,  4'h0,    4'b0010, 2};
    tbl[14] = '{2'b10, 4'd5,  4'h0,    4'b0100, 7};
    rol_seq[0] = 4'b0111;
    rol_seq[1] = 4'b1110;
    rol_seq[2] = 4'b1101;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_mode", sr_mode, 0);
    chk("rst_din", sr_din, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    // First load, cycle by cycle
    cmd_op = 2'b11; cmd_count = 4'd9; cmd_data = 4'b1011;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("load_c1_mode", sr_mode, 2'b11);
    chk("load_c1_din", sr_din, 4'b1011);
    chk("load_c1_busy", busy, 1);
    tick();
    chk("load_c2_done", done, 0);
    tick();
    chk("load_c3_done", done, 1);
    chk("load_c3_result", result, 4'b1011);
    tick();
    chk("load_c4_done", done, 0);
    chk("load_c4_result", result, 4'b1011);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      send(tbl[i].op, tbl[i].cnt, tbl[i].data, lat, res);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_res", i), res, tbl[i].res);
    end

    // Rotate left 3: register sequence and loopback
    send(2'b11, 4'd0, 4'b1011, lat, res);
    cmd_op = 2'b10; cmd_count = 4'd3; cmd_valid = 1'b1;
    wait_ready();
    tick();
    cmd_valid = 1'b0;
    chk("rol3_mode", sr_mode, 2'b10);
    chk("rol3_din", sr_din, 4'b1011);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rol3_q%0d", k + 2), sr_q, rol_seq[k]);
    end
    tick();
    chk("rol3_done", done, 1);
    chk("rol3_result", result, 4'b1101);

    // Count 0: register untouched
    cmd_op = 2'b01; cmd_count = 4'd0; cmd_valid = 1'b1;
    wait_ready();
    tick();
    cmd_valid = 1'b0;
    chk("cnt0_mode_c1", sr_mode, 0);
    chk("cnt0_busy_c1", busy, 1);
    tick();
    chk("cnt0_mode_c2", sr_mode, 0);
    chk("cnt0_done_c2", done, 1);
    chk("cnt0_result", result, 4'b1101);

    // Backpressure: second command waits out rotate 5
    cmd_op = 2'b01; cmd_count = 4'd5; cmd_valid = 1'b1;
    wait_ready();
    tick();
    cmd_op = 2'b11; cmd_data = 4'b0101;
    c = 1; dc = 0; res1 = '0;
    while (!cmd_ready && c < 40) begin
      if (done) begin
        dc = c;
        res1 = result;
      end
      tick();
      c++;
    end
    chk("bp_done_cycle", dc, 7);
    chk("bp_ror5_result", res1, 4'b1110);
    chk("bp_accept_cycle", c, 8);
    tick();
    cmd_valid = 1'b0;
    wait_done(lat, res);
    chk("bp_second_lat", lat, 3);
    chk("bp_second_res", res, 4'b0101);

    // Reset in cycle 2 of rotate left 8
    cmd_op = 2'b10; cmd_count = 4'd8; cmd_valid = 1'b1;
    wait_ready();
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mode", sr_mode, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_after", cmd_ready, 1);
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) nd++;
      tick();
    end
    chk("mid_rst_no_done", nd, 0);
    send(2'b11, 4'd0, 4'b0110, lat, res);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_res", res, 4'b0110);

    // Randomized commands against the arithmetic model
    q_ref = 6;
    for (int i = 0; i < 40; i++) begin
      op  = int'($urandom_range(0, 3));
      cnt = int'($urandom_range(0, 15));
      d   = int'($urandom_range(0, 15));
      send(op[1:0], cnt[3:0], d[3:0], lat, res);
      q_ref = model_res(q_ref, op, cnt, d);
      chk($sformatf("rnd%0d_lat", i), lat,
          model_lat(op, cnt));
      chk($sformatf("rnd%0d_res", i), res, q_ref);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
